// File: rtl/game_flow_controller.sv
// game_flow_controller
//
// Top-level match sequencer for a two-player fighting game. Walks the
// player through the menu, character select, a best-of-N series of timed
// rounds and the match result screen.
//
// Optional feature:
//   GAME_FLOW_PAUSE_EN - when defined, a pause_btn edge during FIGHT freezes
//                        the round (PAUSE state) until the next pause_btn edge.
//                        When undefined, pause_btn is ignored and state code 6
//                        is treated as illegal.
//
// Parameters:
//   ROUNDS_TO_WIN - round wins needed to take the match
//   MAX_ROUNDS    - round limit before the match is forced to end
//   ROUND_SECS    - round timer load value (1..127)
//   TICK_CYCLES   - clk cycles per timer second
//   INTRO_CYCLES  - dwell time in ROUND_INTRO, in clk cycles
//   END_CYCLES    - dwell time in ROUND_END, in clk cycles
//   HP_W          - width of the health inputs
//
// Ports:
//   clk, reset         - clock, asynchronous active-high reset
//   start_btn          - start button level (rising edge used)
//   char_select_done   - character select finished
//   p1_ko, p2_ko       - player knocked out
//   p1_hp, p2_hp       - player health, compared on timeout
//   pause_btn          - pause button level (rising edge used)
//   game_state         - current state code
//   round_num          - current round, 1-based
//   p1_wins, p2_wins   - round wins this match (saturate at 15)
//   round_timer        - seconds left in the round
//   round_result       - 01 P1, 10 P2, 11 draw, 00 none
//   match_winner       - 01 P1, 10 P2, 11 tie, 00 none
//   fight_active       - high while in FIGHT
//   state_changed      - one-cycle pulse after every state change

module game_flow_controller #(
    parameter int ROUNDS_TO_WIN = 2,
    parameter int MAX_ROUNDS    = 5,
    parameter int ROUND_SECS    = 99,
    parameter int TICK_CYCLES   = 100000000,
    parameter int INTRO_CYCLES  = 200000000,
    parameter int END_CYCLES    = 200000000,
    parameter int HP_W          = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_btn,
    input  logic            char_select_done,
    input  logic            p1_ko,
    input  logic            p2_ko,
    input  logic [HP_W-1:0] p1_hp,
    input  logic [HP_W-1:0] p2_hp,
    input  logic            pause_btn,
    output logic [2:0]      game_state,
    output logic [3:0]      round_num,
    output logic [3:0]      p1_wins,
    output logic [3:0]      p2_wins,
    output logic [6:0]      round_timer,
    output logic [1:0]      round_result,
    output logic [1:0]      match_winner,
    output logic            fight_active,
    output logic            state_changed
);

    typedef enum logic [2:0] {
        MAIN_MENU   = 3'd0,
        CHAR_SELECT = 3'd1,
        ROUND_INTRO = 3'd2,
        FIGHT       = 3'd3,
        ROUND_END   = 3'd4,
        MATCH_END   = 3'd5,
        PAUSE       = 3'd6
    } state_t;

    localparam logic [1:0]  RES_NONE = 2'b00;
    localparam logic [1:0]  RES_P1   = 2'b01;
    localparam logic [1:0]  RES_P2   = 2'b10;
    localparam logic [1:0]  RES_DRAW = 2'b11;

    localparam logic [3:0]  WIN_TARGET  = 4'(ROUNDS_TO_WIN);
    localparam logic [3:0]  ROUND_LIMIT = 4'(MAX_ROUNDS);
    localparam logic [6:0]  TIMER_LOAD  = 7'(ROUND_SECS);
    localparam logic [31:0] TICK_LAST   = 32'(TICK_CYCLES - 1);
    localparam logic [31:0] INTRO_LAST  = 32'(INTRO_CYCLES - 1);
    localparam logic [31:0] END_LAST    = 32'(END_CYCLES - 1);

    state_t      state_reg;
    state_t      state_next;
    logic        start_q;
    logic        start_armed;
    logic        start_edge;
    logic [31:0] dwell_cnt;
    logic [31:0] tick_cnt;
    logic [1:0]  outcome;
    logic        match_over;

    // A start edge needs the button to have been seen low at least once since
    // reset, so a button held through reset release does not skip the menu.
    assign start_edge = start_btn & ~start_q & start_armed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q     <= 1'b0;
            start_armed <= 1'b0;
        end else begin
            start_q     <= start_btn;
            start_armed <= start_armed | ~start_btn;
        end
    end

`ifdef GAME_FLOW_PAUSE_EN
    logic pause_q;
    logic pause_edge;

    assign pause_edge = pause_btn & ~pause_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pause_q <= 1'b0;
        end else begin
            pause_q <= pause_btn;
        end
    end
`else
    logic unused_pause;
    assign unused_pause = pause_btn;
`endif

    // Round outcome for the current cycle. A knockout always beats a timeout;
    // the result is only acted upon while in FIGHT.
    always_comb begin
        outcome = RES_NONE;
        if (p1_ko && p2_ko) begin
            outcome = RES_DRAW;
        end else if (p1_ko) begin
            outcome = RES_P2;
        end else if (p2_ko) begin
            outcome = RES_P1;
        end else if (round_timer == 7'd0) begin
            if (p1_hp > p2_hp) begin
                outcome = RES_P1;
            end else if (p2_hp > p1_hp) begin
                outcome = RES_P2;
            end else begin
                outcome = RES_DRAW;
            end
        end
    end

    assign match_over = (p1_wins >= WIN_TARGET) || (p2_wins >= WIN_TARGET) ||
                        (round_num >= ROUND_LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= MAIN_MENU;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. Unused codes (and PAUSE when the feature is compiled
    // out) fall through to the default and recover to MAIN_MENU.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            MAIN_MENU: begin
                if (start_edge) state_next = CHAR_SELECT;
            end
            CHAR_SELECT: begin
                if (char_select_done) state_next = ROUND_INTRO;
            end
            ROUND_INTRO: begin
                if (dwell_cnt == INTRO_LAST) state_next = FIGHT;
            end
            FIGHT: begin
                if (outcome != RES_NONE) begin
                    state_next = ROUND_END;
                end
`ifdef GAME_FLOW_PAUSE_EN
                else if (pause_edge) begin
                    state_next = PAUSE;
                end
`endif
            end
            ROUND_END: begin
                if (dwell_cnt == END_LAST) begin
                    state_next = match_over ? MATCH_END : ROUND_INTRO;
                end
            end
            MATCH_END: begin
                if (start_edge) state_next = MAIN_MENU;
            end
`ifdef GAME_FLOW_PAUSE_EN
            PAUSE: begin
                if (pause_edge) state_next = FIGHT;
            end
`endif
            default: begin
                state_next = MAIN_MENU;
            end
        endcase
    end

    // Match bookkeeping, driven by state transitions. The tick counter only
    // advances on cycles that stay in FIGHT, so it is frozen while paused and
    // picks up exactly where it left off on resume.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_changed <= 1'b0;
            dwell_cnt     <= '0;
            tick_cnt      <= '0;
            round_num     <= '0;
            p1_wins       <= '0;
            p2_wins       <= '0;
            round_timer   <= '0;
            round_result  <= RES_NONE;
            match_winner  <= RES_NONE;
        end else begin
            state_changed <= (state_next != state_reg);

            if ((state_next != state_reg) ||
                ((state_reg != ROUND_INTRO) && (state_reg != ROUND_END))) begin
                dwell_cnt <= '0;
            end else begin
                dwell_cnt <= dwell_cnt + 32'd1;
            end

            if ((state_reg == CHAR_SELECT) && (state_next == ROUND_INTRO)) begin
                p1_wins      <= '0;
                p2_wins      <= '0;
                match_winner <= RES_NONE;
                round_result <= RES_NONE;
                round_num    <= 4'd1;
            end

            if ((state_reg != ROUND_INTRO) && (state_next == ROUND_INTRO)) begin
                round_timer <= TIMER_LOAD;
                tick_cnt    <= '0;
            end

            if ((state_reg == FIGHT) && (state_next == FIGHT)) begin
                if (tick_cnt == TICK_LAST) begin
                    tick_cnt <= '0;
                    if (round_timer != 7'd0) begin
                        round_timer <= round_timer - 7'd1;
                    end
                end else begin
                    tick_cnt <= tick_cnt + 32'd1;
                end
            end

            if ((state_reg == FIGHT) && (state_next == ROUND_END)) begin
                round_result <= outcome;
                if ((outcome == RES_P1) && (p1_wins != 4'd15)) begin
                    p1_wins <= p1_wins + 4'd1;
                end
                if ((outcome == RES_P2) && (p2_wins != 4'd15)) begin
                    p2_wins <= p2_wins + 4'd1;
                end
            end

            if ((state_reg == ROUND_END) && (state_next == ROUND_INTRO)) begin
                round_num    <= round_num + 4'd1;
                round_result <= RES_NONE;
            end

            if ((state_reg != MATCH_END) && (state_next == MATCH_END)) begin
                if (p1_wins > p2_wins) begin
                    match_winner <= RES_P1;
                end else if (p2_wins > p1_wins) begin
                    match_winner <= RES_P2;
                end else begin
                    match_winner <= RES_DRAW;
                end
            end
        end
    end

    assign game_state   = state_reg;
    assign fight_active = (state_reg == FIGHT);

endmodule

// File: tb/tb_game_flow_controller.sv
// tb_game_flow_controller
//
// Directed, table-driven bench for game_flow_controller using small timing
// parameters (TICK_CYCLES=4, ROUND_SECS=3, INTRO_CYCLES=2, END_CYCLES=2,
// ROUNDS_TO_WIN=2, MAX_ROUNDS=5). Each vector holds inputs for a number of
// clock cycles and then lists the outputs expected afterwards. The PAUSE
// sequence is only exercised when GAME_FLOW_PAUSE_EN is defined.

module tb_game_flow_controller;

    logic       clk;
    logic       reset;
    logic       start_btn;
    logic       char_select_done;
    logic       p1_ko;
    logic       p2_ko;
    logic [7:0] p1_hp;
    logic [7:0] p2_hp;
    logic       pause_btn;
    logic [2:0] game_state;
    logic [3:0] round_num;
    logic [3:0] p1_wins;
    logic [3:0] p2_wins;
    logic [6:0] round_timer;
    logic [1:0] round_result;
    logic [1:0] match_winner;
    logic       fight_active;
    logic       state_changed;

    int checks;
    int failures;

    typedef struct {
        logic start;
        logic done;
        logic ko1;
        logic ko2;
        logic pause;
        int   hp1;
        int   hp2;
        int   cycles;
        int   st;
        int   rn;
        int   w1;
        int   w2;
        int   tmr;
        int   res;
        int   win;
        int   chg;
    } vec_t;

    vec_t vecs[$];

    game_flow_controller #(
        .ROUNDS_TO_WIN(2),
        .MAX_ROUNDS(5),
        .ROUND_SECS(3),
        .TICK_CYCLES(4),
        .INTRO_CYCLES(2),
        .END_CYCLES(2),
        .HP_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start_btn(start_btn),
        .char_select_done(char_select_done),
        .p1_ko(p1_ko),
        .p2_ko(p2_ko),
        .p1_hp(p1_hp),
        .p2_hp(p2_hp),
        .pause_btn(pause_btn),
        .game_state(game_state),
        .round_num(round_num),
        .p1_wins(p1_wins),
        .p2_wins(p2_wins),
        .round_timer(round_timer),
        .round_result(round_result),
        .match_winner(match_winner),
        .fight_active(fight_active),
        .state_changed(state_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net: the whole run is a few hundred cycles.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic s, input logic d, input logic k1,
                                input logic k2, input logic p, input int h1,
                                input int h2, input int n, input int st,
                                input int rn, input int w1, input int w2,
                                input int tmr, input int res, input int win,
                                input int chg);
        vec_t v;
        v.start = s;   v.done = d;   v.ko1 = k1;  v.ko2 = k2;  v.pause = p;
        v.hp1 = h1;    v.hp2 = h2;   v.cycles = n;
        v.st = st;     v.rn = rn;    v.w1 = w1;   v.w2 = w2;   v.tmr = tmr;
        v.res = res;   v.win = win;  v.chg = chg;
        return v;
    endfunction

    task automatic checkField(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        checkField({tag, " game_state"},    int'(game_state),    v.st);
        checkField({tag, " round_num"},     int'(round_num),     v.rn);
        checkField({tag, " p1_wins"},       int'(p1_wins),       v.w1);
        checkField({tag, " p2_wins"},       int'(p2_wins),       v.w2);
        checkField({tag, " round_timer"},   int'(round_timer),   v.tmr);
        checkField({tag, " round_result"},  int'(round_result),  v.res);
        checkField({tag, " match_winner"},  int'(match_winner),  v.win);
        checkField({tag, " fight_active"},  int'(fight_active),  (v.st == 3) ? 1 : 0);
        checkField({tag, " state_changed"}, int'(state_changed), v.chg);
    endtask

    // Drive the vector's inputs, clock it the requested number of cycles and
    // sample 1 time unit after the final rising edge.
    task automatic applyStimulus(input vec_t v);
        start_btn        = v.start;
        char_select_done = v.done;
        p1_ko            = v.ko1;
        p2_ko            = v.ko2;
        pause_btn        = v.pause;
        p1_hp            = 8'(v.hp1);
        p2_hp            = 8'(v.hp2);
        repeat (v.cycles) @(posedge clk);
        #1;
    endtask

    task automatic runVector(input string tag, input vec_t v);
        applyStimulus(v);
        checkOutput(tag, v);
    endtask

    initial begin
        int pz;
        checks           = 0;
        failures         = 0;
        reset            = 1'b1;
        start_btn        = 1'b0;
        char_select_done = 1'b0;
        p1_ko            = 1'b0;
        p2_ko            = 1'b0;
        pause_btn        = 1'b0;
        p1_hp            = 8'd50;
        p2_hp            = 8'd30;

        //          s  d  k1 k2 p  hp1 hp2  n  st rn w1 w2 t res win chg
        // First match: timeout win for P1, then a p2_ko win ends the match.
        vecs.push_back(mk(0, 0, 0, 0, 0, 50, 30,  1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 50, 30,  1, 1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 50, 30,  1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 50, 30,  1, 2, 1, 0, 0, 3, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 50, 30,  1, 2, 1, 0, 0, 3, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 50, 30,  1, 3, 1, 0, 0, 3, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 50, 30,  3, 3, 1, 0, 0, 3, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 50, 30,  1, 3, 1, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 50, 30,  4, 3, 1, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 50, 30,  4, 3, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 50, 30,  1, 4, 1, 1, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 50, 30,  1, 4, 1, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 50, 30,  1, 2, 2, 1, 0, 3, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 50, 30,  2, 3, 2, 1, 0, 3, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 50, 30,  1, 4, 2, 2, 0, 3, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 50, 30,  2, 5, 2, 2, 0, 3, 1, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, 50, 30,  2, 5, 2, 2, 0, 3, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 50, 30,  1, 0, 2, 2, 0, 3, 1, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 50, 30,  2, 0, 2, 2, 0, 3, 1, 1, 0));
        // Second match: five double-KO draws reach the round limit.
        vecs.push_back(mk(0, 0, 0, 0, 0, 50, 30,  1, 0, 2, 2, 0, 3, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 50, 30,  1, 1, 2, 2, 0, 3, 1, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 50, 30,  1, 2, 1, 0, 0, 3, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 50, 30,  2, 3, 1, 0, 0, 3, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 50, 30,  1, 4, 1, 0, 0, 3, 3, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 50, 30,  2, 2, 2, 0, 0, 3, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 50, 30,  3, 4, 2, 0, 0, 3, 3, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 50, 30, 15, 4, 5, 0, 0, 3, 3, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 50, 30,  2, 5, 5, 0, 0, 3, 3, 3, 1));
        // Third match: KO beats timeout, equal-hp draw, P2 timeout win.
        vecs.push_back(mk(1, 0, 0, 0, 0, 50, 30,  1, 0, 5, 0, 0, 3, 3, 3, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 50, 30,  1, 0, 5, 0, 0, 3, 3, 3, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 50, 30,  1, 1, 5, 0, 0, 3, 3, 3, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 60, 20,  1, 2, 1, 0, 0, 3, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 60, 20,  2, 3, 1, 0, 0, 3, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 60, 20, 12, 3, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 60, 20,  1, 4, 1, 0, 1, 0, 2, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 40, 40,  2, 2, 2, 0, 1, 3, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 40, 40,  2, 3, 2, 0, 1, 3, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 40, 40, 12, 3, 2, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 40, 40,  1, 4, 2, 0, 1, 0, 3, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 10, 70,  4, 3, 3, 0, 1, 3, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 10, 70, 13, 4, 3, 0, 2, 0, 2, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 10, 70,  2, 5, 3, 0, 2, 0, 2, 2, 1));

        #12;
        checkOutput("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            runVector($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset in the middle of a round. Without the pause feature a pause
        // edge is also thrown in and must not disturb the fight.
`ifdef GAME_FLOW_PAUSE_EN
        pz = 0;
`else
        pz = 1;
`endif
        runVector("rst_a", mk(1, 0, 0, 0, 0, 50, 30, 1, 0, 3, 0, 2, 0, 2, 2, 1));
        runVector("rst_b", mk(0, 0, 0, 0, 0, 50, 30, 1, 0, 3, 0, 2, 0, 2, 2, 0));
        runVector("rst_c", mk(1, 0, 0, 0, 0, 50, 30, 1, 1, 3, 0, 2, 0, 2, 2, 1));
        runVector("rst_d", mk(0, 1, 0, 0, 0, 50, 30, 1, 2, 1, 0, 0, 3, 0, 0, 1));
        runVector("rst_e", mk(0, 0, 0, 0, 0, 50, 30, 2, 3, 1, 0, 0, 3, 0, 0, 1));
        runVector("rst_f", mk(0, 0, 0, 0, logic'(pz), 50, 30, 4, 3, 1, 0, 0, 2, 0, 0, 0));
        start_btn = 1'b1;
        #3;
        reset = 1'b1;
        #2;
        checkOutput("rst_async", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        reset = 1'b0;

        // Start held through reset release must not count as an edge.
        runVector("hold_a", mk(1, 0, 0, 0, 0, 50, 30, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        runVector("hold_b", mk(0, 0, 0, 0, 0, 50, 30, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        runVector("hold_c", mk(1, 0, 0, 0, 0, 50, 30, 1, 1, 0, 0, 0, 0, 0, 0, 1));

`ifdef GAME_FLOW_PAUSE_EN
        // Pause at timer=2 with two ticks already counted; the resumed round
        // must decrement after the two remaining tick cycles, not four.
        runVector("pz_a", mk(0, 1, 0, 0, 0, 50, 30,  1, 2, 1, 0, 0, 3, 0, 0, 1));
        runVector("pz_b", mk(0, 0, 0, 0, 0, 50, 30,  2, 3, 1, 0, 0, 3, 0, 0, 1));
        runVector("pz_c", mk(0, 0, 0, 0, 0, 50, 30,  4, 3, 1, 0, 0, 2, 0, 0, 0));
        runVector("pz_d", mk(0, 0, 0, 0, 0, 50, 30,  2, 3, 1, 0, 0, 2, 0, 0, 0));
        runVector("pz_e", mk(0, 0, 0, 0, 1, 50, 30,  1, 6, 1, 0, 0, 2, 0, 0, 1));
        runVector("pz_f", mk(0, 0, 1, 0, 1, 50, 30, 20, 6, 1, 0, 0, 2, 0, 0, 0));
        runVector("pz_g", mk(0, 0, 0, 0, 0, 50, 30,  1, 6, 1, 0, 0, 2, 0, 0, 0));
        runVector("pz_h", mk(0, 0, 0, 0, 1, 50, 30,  1, 3, 1, 0, 0, 2, 0, 0, 1));
        runVector("pz_i", mk(0, 0, 0, 0, 1, 50, 30,  1, 3, 1, 0, 0, 2, 0, 0, 0));
        runVector("pz_j", mk(0, 0, 0, 0, 1, 50, 30,  1, 3, 1, 0, 0, 1, 0, 0, 0));
        runVector("pz_k", mk(0, 0, 0, 0, 0, 50, 30,  1, 3, 1, 0, 0, 1, 0, 0, 0));
        runVector("pz_l", mk(0, 0, 0, 1, 1, 50, 30,  1, 4, 1, 1, 0, 1, 1, 0, 1));
`else
        // Without the feature, pause edges leave the round running normally.
        runVector("np_a", mk(0, 1, 0, 0, 0, 50, 30, 1, 2, 1, 0, 0, 3, 0, 0, 1));
        runVector("np_b", mk(0, 0, 0, 0, 0, 50, 30, 2, 3, 1, 0, 0, 3, 0, 0, 1));
        runVector("np_c", mk(0, 0, 0, 0, 1, 50, 30, 4, 3, 1, 0, 0, 2, 0, 0, 0));
        runVector("np_d", mk(0, 0, 0, 0, 0, 50, 30, 1, 3, 1, 0, 0, 2, 0, 0, 0));
        runVector("np_e", mk(0, 0, 0, 0, 1, 50, 30, 3, 3, 1, 0, 0, 1, 0, 0, 0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
